// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path.
// Contents: default frame-buffer geometry, capture FSM state encoding,
// RGB332 field positions and primary colour constants.
package cam_pkg;

    localparam int DEF_SCREEN_WIDTH  = 176;
    localparam int DEF_SCREEN_HEIGHT = 144;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_VBLANK = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DONE   = 3'd4
    } cap_state_t;

    // RGB332 pixel layout: RRRGGGBB
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;

endpackage

// File: rtl/rgb565_to_rgb332_packer.sv
// Packs an RGB565 byte pair from the camera into one RGB332 pixel.
// Ports:
//   clk, reset   - capture clock, synchronous active-high reset
//   clear        - force phase back to byte 0 (line end / frame start)
//   byte_en      - cam_byte is a valid pixel byte this cycle
//   cam_byte     - camera byte
//   phase        - 0: next byte is the first of a pair, 1: second
//   pixel_done   - second byte of a pair is being accepted this cycle
//   pixel        - packed pixel, valid while pixel_done is high
module rgb565_to_rgb332_packer
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] cam_byte,
    output logic       phase,
    output logic       pixel_done,
    output logic [7:0] pixel
);

    // Top three red bits and top three green bits from the first byte.
    logic [5:0] hold;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= 1'b0;
            hold  <= '0;
        end else if (byte_en) begin
            if (!phase)
                hold <= {cam_byte[7:5], cam_byte[2:0]};
            phase <= ~phase;
        end
    end

    assign pixel_done = byte_en & phase;

    // Blue comes straight from the second byte so the pixel is ready in
    // the same cycle that byte is accepted.
    always_comb begin
        pixel              = '0;
        pixel[R_MSB:R_LSB] = hold[5:3];
        pixel[G_MSB:G_LSB] = hold[2:0];
        pixel[B_MSB:B_LSB] = cam_byte[4:3];
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture controller: OV7670 bus to frame-buffer write port.
// Arms on request, aligns to a frame boundary, packs RGB565 pairs to
// RGB332 and issues clipped write addresses built from a running line base.
// Ports:
//   CLK, RESET            - capture clock, synchronous active-high reset
//   CAPTURE_REQ           - single-shot request (honoured in IDLE only)
//   CAPTURE_EN            - continuous capture while high
//   V_SYNC, HREF, CAM_DATA- camera bus
//   W_ADDR, W_DATA, W_EN  - frame-buffer write port
//   FRAME_DONE            - one-cycle pulse at end of a captured frame
//   FRAME_ERR             - 1 if the last captured frame was malformed
//   BUSY                  - high outside IDLE
//   LINE_COUNT            - lines completed in the current/last frame
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int ADDR_W        = 15,
    parameter int CNT_W         = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CAPTURE_REQ,
    input  logic              CAPTURE_EN,
    input  logic              V_SYNC,
    input  logic              HREF,
    input  logic [7:0]        CAM_DATA,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR,
    output logic              BUSY,
    output logic [CNT_W-1:0]  LINE_COUNT
);

    localparam logic [CNT_W-1:0]  WIDTH_C   = CNT_W'(SCREEN_WIDTH);
    localparam logic [CNT_W-1:0]  HEIGHT_C  = CNT_W'(SCREEN_HEIGHT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

    cap_state_t        state;
    logic              href_q;
    logic              vs_q;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [ADDR_W-1:0] line_base;
    logic              err_flag;

    logic              line_end;
    logic              vs_rise;
    logic              byte_en;
    logic              pack_clear;
    logic              phase;
    logic              pixel_done;
    logic [7:0]        pixel;
    logic [CNT_W-1:0]  x_inc;
    logic [CNT_W-1:0]  y_inc;
    logic [CNT_W-1:0]  y_after;
    logic              line_err;

    assign line_end = href_q & ~HREF;
    assign vs_rise  = V_SYNC & ~vs_q;

    // A byte arriving together with the V_SYNC rise belongs to a truncated
    // line and is never packed.
    assign byte_en    = (state == ST_ACTIVE) && HREF && !vs_rise;
    assign pack_clear = ((state == ST_VBLANK) && !V_SYNC) ||
                        ((state == ST_ACTIVE) && (line_end || vs_rise));

    assign x_inc    = (x == CNT_MAX) ? x : x + CNT_W'(1);
    assign y_inc    = (y == CNT_MAX) ? y : y + CNT_W'(1);
    assign y_after  = line_end ? y_inc : y;
    assign line_err = (x != WIDTH_C) || phase;

    rgb565_to_rgb332_packer u_packer (
        .clk        (CLK),
        .reset      (RESET),
        .clear      (pack_clear),
        .byte_en    (byte_en),
        .cam_byte   (CAM_DATA),
        .phase      (phase),
        .pixel_done (pixel_done),
        .pixel      (pixel)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            href_q     <= 1'b0;
            vs_q       <= 1'b0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            err_flag   <= 1'b0;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
            BUSY       <= 1'b0;
            LINE_COUNT <= '0;
        end else begin
            href_q     <= HREF;
            vs_q       <= V_SYNC;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (CAPTURE_REQ || CAPTURE_EN) begin
                        state <= ST_ARM;
                        BUSY  <= 1'b1;
                    end
                end

                // Wait for blanking so capture never starts mid-frame.
                ST_ARM: begin
                    if (V_SYNC)
                        state <= ST_VBLANK;
                end

                ST_VBLANK: begin
                    if (!V_SYNC) begin
                        x          <= '0;
                        y          <= '0;
                        line_base  <= '0;
                        LINE_COUNT <= '0;
                        err_flag   <= 1'b0;
                        state      <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (line_end) begin
                        y          <= y_inc;
                        LINE_COUNT <= y_inc;
                        x          <= '0;
                        // Base stops at the first line past the screen, so
                        // W_ADDR can never leave the buffer.
                        if (y < HEIGHT_C)
                            line_base <= line_base + LINE_STEP;
                        if (line_err)
                            err_flag <= 1'b1;
                    end else if (pixel_done) begin
                        x <= x_inc;
                        if ((x < WIDTH_C) && (y < HEIGHT_C)) begin
                            W_EN   <= 1'b1;
                            W_ADDR <= line_base + ADDR_W'(x);
                            W_DATA <= pixel;
                        end
                    end

                    if (vs_rise) begin
                        state      <= ST_DONE;
                        FRAME_DONE <= 1'b1;
                        if (HREF)
                            err_flag <= 1'b1;
                        FRAME_ERR  <= err_flag || HREF || (line_end && line_err) ||
                                      (y_after != HEIGHT_C);
                    end
                end

                ST_DONE: begin
                    if (CAPTURE_EN) begin
                        state <= ST_VBLANK;
                    end else begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: directed frame scenarios with random pixel
// bytes and line shapes; expected writes come from a frame-level model
// (address = line * width + pixel, clipped to the screen).
module tb_cam_capture_ctrl;

    localparam int W  = 176;
    localparam int H  = 144;
    localparam int AW = 15;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          capture_req = 1'b0;
    logic          capture_en = 1'b0;
    logic          v_sync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_data;
    logic          w_en;
    logic          frame_done;
    logic          frame_err;
    logic          busy;
    logic [CW-1:0] line_count;

    int vectors = 0;
    int miscompares = 0;

    int         exp_addr[$];
    int         obs_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] obs_data[$];

    int   done_cnt = 0;
    int   dbl_pulse = 0;
    int   busy_drop = 0;
    bit   watch_busy = 1'b0;
    logic w_en_prev = 1'b0;

    // frame model state
    int         m_lines;
    bit         m_err;
    logic [7:0] m_b0;

    cam_capture_ctrl #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .ADDR_W        (AW),
        .CNT_W         (CW)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .CAPTURE_REQ (capture_req),
        .CAPTURE_EN  (capture_en),
        .V_SYNC      (v_sync),
        .HREF        (href),
        .CAM_DATA    (cam_data),
        .W_ADDR      (w_addr),
        .W_DATA      (w_data),
        .W_EN        (w_en),
        .FRAME_DONE  (frame_done),
        .FRAME_ERR   (frame_err),
        .BUSY        (busy),
        .LINE_COUNT  (line_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_en) begin
            obs_addr.push_back(int'(w_addr));
            obs_data.push_back(w_data);
        end
        if (w_en && w_en_prev)
            dbl_pulse++;
        w_en_prev = w_en;
        if (frame_done)
            done_cnt++;
        if (watch_busy && !busy)
            busy_drop++;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive byte i of the current line; the model records a write for each
    // completed pair that lands on the screen.
    task automatic drive_byte(input int i, input bit fixed, input bit live);
        logic [7:0] b;
        b = fixed ? ((i % 2 == 0) ? 8'hE7 : 8'h18) : 8'($urandom);
        cam_data = b;
        if (i % 2 == 0) begin
            m_b0 = b;
        end else if (live && (i / 2) < W && m_lines < H) begin
            exp_addr.push_back(m_lines * W + i / 2);
            exp_data.push_back(8'((m_b0 & 8'hE0) | ((m_b0 & 8'h07) << 2) | ((b >> 3) & 8'h03)));
        end
        tick();
    endtask

    // cut=1: V_SYNC rises while HREF is still high, dropping the pair in flight.
    task automatic send_line(input int nbytes, input int gap, input bit fixed,
                             input bit live, input bit cut);
        href = 1'b1;
        for (int i = 0; i < nbytes; i++)
            drive_byte(i, fixed, live);
        if (cut) begin
            v_sync   = 1'b1;
            cam_data = 8'($urandom);
            tick();
            if (live) m_err = 1'b1;
        end else if (live) begin
            m_lines++;
            if (nbytes != 2 * W) m_err = 1'b1;
        end
        href     = 1'b0;
        cam_data = 8'h00;
        tick(gap);
    endtask

    task automatic begin_frame();
        v_sync = 1'b1;
        tick(3);
        v_sync = 1'b0;
        tick(2);
        m_lines = 0;
        m_err   = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        int bad0;
        chk({tag, ".wr_count"}, obs_addr.size(), exp_addr.size());
        n    = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        bad0 = miscompares;
        for (int i = 0; i < n && (miscompares - bad0) < 4; i++) begin
            chk({tag, ".addr"}, obs_addr[i], exp_addr[i]);
            chk({tag, ".data"}, obs_data[i], exp_data[i]);
        end
        obs_addr.delete();
        obs_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic finish_frame(input string tag);
        v_sync = 1'b1;
        tick(3);
        compare_writes(tag);
        chk({tag, ".frame_err"}, frame_err, (m_err || m_lines != H) ? 1 : 0);
        chk({tag, ".line_count"}, line_count, (m_lines > 255) ? 255 : m_lines);
    endtask

    task automatic request();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    initial begin
        // ---- reset state
        rst = 1'b1;
        tick(2);
        chk("rst.w_en", w_en, 0);
        chk("rst.w_addr", w_addr, 0);
        chk("rst.w_data", w_data, 0);
        chk("rst.frame_done", frame_done, 0);
        chk("rst.frame_err", frame_err, 0);
        chk("rst.busy", busy, 0);
        chk("rst.line_count", line_count, 0);
        rst = 1'b0;
        tick(2);
        chk("idle.busy", busy, 0);

        // ---- full single-shot frame, constant white pixels
        request();
        chk("full.busy_armed", busy, 1);
        begin_frame();
        for (int l = 0; l < H; l++) begin
            capture_req = (l == 70);   // ignored outside IDLE
            send_line(2 * W, 10, 1'b1, 1'b1, 1'b0);
        end
        capture_req = 1'b0;
        finish_frame("full");
        chk("full.last_addr", w_addr, W * H - 1);
        chk("full.last_data", w_data, 8'hFF);
        chk("full.done_cnt", done_cnt, 1);
        chk("full.busy_idle", busy, 0);

        // ---- request while V_SYNC low mid-frame: nothing until next frame
        v_sync = 1'b0;
        tick(2);
        send_line(20, 3, 1'b0, 1'b0, 1'b0);
        request();
        send_line(40, 3, 1'b0, 1'b0, 1'b0);
        send_line(40, 3, 1'b0, 1'b0, 1'b0);
        chk("mid.no_early_writes", obs_addr.size(), 0);
        begin_frame();
        for (int l = 0; l < 4; l++)
            send_line(10, 3, 1'b0, 1'b1, 1'b0);
        chk("mid.first_addr", (obs_addr.size() > 0) ? obs_addr[0] : -1, 0);
        finish_frame("mid");
        chk("mid.done_cnt", done_cnt, 2);

        // ---- oversize lines and frame: clipping in x and y
        request();
        begin_frame();
        for (int l = 0; l < 3; l++)
            send_line(400, 2, 1'b0, 1'b1, 1'b0);
        for (int l = 0; l < 147; l++)
            send_line(2, 2, 1'b0, 1'b1, 1'b0);
        finish_frame("clip");
        chk("clip.done_cnt", done_cnt, 3);

        // ---- odd byte count line
        request();
        begin_frame();
        send_line(353, 4, 1'b0, 1'b1, 1'b0);
        send_line(352, 4, 1'b0, 1'b1, 1'b0);
        send_line(8, 4, 1'b0, 1'b1, 1'b0);
        finish_frame("odd");
        chk("odd.done_cnt", done_cnt, 4);

        // ---- V_SYNC rises mid-line with a pixel in flight
        request();
        begin_frame();
        send_line(30, 3, 1'b0, 1'b1, 1'b0);
        send_line(13, 0, 1'b0, 1'b1, 1'b1);
        finish_frame("vs_href");
        chk("vs_href.done_cnt", done_cnt, 5);
        chk("vs_href.busy", busy, 0);

        // ---- continuous mode, 3 frames, enable dropped during the third
        capture_en = 1'b1;
        tick();
        watch_busy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int nl;
            begin_frame();
            nl = $urandom_range(2, 5);
            for (int l = 0; l < nl; l++) begin
                send_line($urandom_range(1, 24), $urandom_range(1, 4), 1'b0, 1'b1, 1'b0);
                if (f == 2) capture_en = 1'b0;
            end
            if (f == 2) watch_busy = 1'b0;
            finish_frame("cont");
        end
        chk("cont.done_cnt", done_cnt, 8);
        chk("cont.busy_held", busy_drop, 0);
        chk("cont.busy_idle", busy, 0);

        // ---- reset at pixel 5000
        request();
        begin_frame();
        for (int l = 0; l < 28; l++)
            send_line(2 * W, 2, 1'b0, 1'b1, 1'b0);
        href = 1'b1;
        for (int i = 0; i < 144; i++)
            drive_byte(i, 1'b0, 1'b1);
        rst      = 1'b1;
        cam_data = 8'($urandom);
        tick();
        chk("midrst.w_en", w_en, 0);
        chk("midrst.w_addr", w_addr, 0);
        chk("midrst.w_data", w_data, 0);
        chk("midrst.frame_done", frame_done, 0);
        chk("midrst.frame_err", frame_err, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.line_count", line_count, 0);
        rst  = 1'b0;
        href = 1'b0;
        compare_writes("pre_rst");
        tick(2);
        send_line(40, 3, 1'b0, 1'b0, 1'b0);
        v_sync = 1'b1;
        tick(3);
        v_sync = 1'b0;
        tick(2);
        send_line(40, 3, 1'b0, 1'b0, 1'b0);
        chk("post_rst.no_writes", obs_addr.size(), 0);
        request();
        begin_frame();
        send_line(12, 3, 1'b0, 1'b1, 1'b0);
        send_line(12, 3, 1'b0, 1'b1, 1'b0);
        finish_frame("post_rst");
        chk("post_rst.done_cnt", done_cnt, 9);

        chk("w_en.single_cycle", dbl_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
